// File: rtl/muldiv_seq.sv
// Iterative multiply/divide unit owning the architectural HI/LO registers.
// One 32-step shift-add multiply or restoring divide per request; stalls the pipeline while running.
module muldiv_seq #(
   parameter int         WIDTH    = 32,
   parameter int         CNT_W    = 5,
   parameter logic [2:0] OP_MULT  = 3'b000,
   parameter logic [2:0] OP_MULTU = 3'b001,
   parameter logic [2:0] OP_DIV   = 3'b010,
   parameter logic [2:0] OP_DIVU  = 3'b011,
   parameter logic [2:0] OP_MTHI  = 3'b100,
   parameter logic [2:0] OP_MTLO  = 3'b101
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             stall_req,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] opnd, acc_hi, acc_lo;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic             is_div, neg_q, neg_r, done_q;

   logic             is_mul_op, is_div_op, sgn_op, div_zero;
   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_shift;
   logic [WIDTH+1:0] div_diff;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0] quo_fix, rem_fix;

   function automatic logic [WIDTH-1:0] abs_val(input logic signed [WIDTH-1:0] v, input logic sgn);
      return (sgn && v < 0) ? -v : v;
   endfunction

   function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] v, input logic n);
      return n ? -v : v;
   endfunction

   always_comb begin
      is_mul_op = start && (op == OP_MULT || op == OP_MULTU);
      is_div_op = start && (op == OP_DIV  || op == OP_DIVU);
      sgn_op    = (op == OP_MULT || op == OP_DIV);
      div_zero  = is_div_op && (src_b == '0);
   end

   // Iteration datapath: multiply keeps {acc_hi,acc_lo} as the shifting product/multiplier,
   // divide keeps acc_hi as partial remainder and acc_lo as dividend/quotient.
   always_comb begin
      mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
      div_shift = {acc_hi, acc_lo[WIDTH-1]};
      div_diff  = {1'b0, div_shift} - {2'b00, opnd};
      prod_fix  = cond_neg2({acc_hi, acc_lo}, neg_q);
      quo_fix   = cond_neg(acc_lo, neg_q);
      rem_fix   = cond_neg(acc_hi, neg_r);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (is_mul_op || (is_div_op && !div_zero)) state_nx = RUN;
         RUN:  if (cnt == CNT_W'(WIDTH-1)) state_nx = FIX;
         FIX:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
      if (flush) state_nx = IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         opnd   <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         is_div <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: if (start && !flush) begin
               if (op == OP_MTHI) begin
                  hi_q <= src_a;
               end else if (op == OP_MTLO) begin
                  lo_q <= src_a;
               end else if (is_mul_op) begin
                  opnd   <= abs_val(src_a, sgn_op);
                  acc_lo <= abs_val(src_b, sgn_op);
                  acc_hi <= '0;
                  cnt    <= '0;
                  is_div <= 1'b0;
                  neg_q  <= sgn_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r  <= 1'b0;
               end else if (div_zero) begin
                  lo_q   <= {WIDTH{1'b1}};
                  hi_q   <= src_a;
                  done_q <= 1'b1;
               end else if (is_div_op) begin
                  opnd   <= abs_val(src_b, sgn_op);
                  acc_lo <= abs_val(src_a, sgn_op);
                  acc_hi <= '0;
                  cnt    <= '0;
                  is_div <= 1'b1;
                  neg_q  <= sgn_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
                  neg_r  <= sgn_op && src_a[WIDTH-1];
               end
            end
            RUN: if (!flush) begin
               cnt <= cnt + CNT_W'(1);
               if (is_div) begin
                  if (!div_diff[WIDTH+1]) begin
                     acc_hi <= div_diff[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                  end else begin
                     acc_hi <= div_shift[WIDTH-1:0];
                     acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc_hi <= mul_sum[WIDTH:1];
                  acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
               end
            end
            FIX: if (!flush) begin
               // Sign correction and architectural commit
               if (is_div) begin
                  hi_q <= rem_fix;
                  lo_q <= quo_fix;
               end else begin
                  hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                  lo_q <= prod_fix[WIDTH-1:0];
               end
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign busy      = (state != IDLE);
   assign stall_req = busy;
   assign done      = done_q;
   assign hi        = hi_q;
   assign lo        = lo_q;

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Iterative multiply/divide sequencer that owns the architectural HI/LO registers (GPR[32]/GPR[33]) for the multistage pipeline.
- Accepts one MULT/MULTU/DIV/DIVU/MTHI/MTLO request from EX.
- Runs a 32-step shift-add multiply or restoring divide.
- Holds the pipeline via stall_req until the result is committed to HI/LO.
- hi/lo feed the HI/LO forwarding muxes as the ID_EX-stage source values.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width (2^CNT_W == WIDTH).
- OP_MULT, 3'b000, signed multiply.
- OP_MULTU, 3'b001, unsigned multiply.
- OP_DIV, 3'b010, signed divide.
- OP_DIVU, 3'b011, unsigned divide.
- OP_MTHI, 3'b100, write src_a to HI.
- OP_MTLO, 3'b101, write src_a to LO.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request valid from EX (one cycle per instruction).
- op  in  3  operation select, encodings per parameters; other codes are ignored.
- src_a  in  WIDTH  rs value (multiplicand / dividend / MTxx data).
- src_b  in  WIDTH  rt value (multiplier / divisor).
- flush  in  1  exception/flush: abort any in-flight operation.
- busy  out  1  high while not IDLE.
- done  out  1  one-cycle pulse after HI/LO commit of a mul/div.
- stall_req  out  1  pipeline hold request; equals busy.
- hi  out  WIDTH  architectural HI.
- lo  out  WIDTH  architectural LO.

Behaviour:
- Reset (rst_n low, async): state=IDLE, hi=0, lo=0, busy=0, done=0, stall_req=0, counter=0, internal accumulators=0. Reset mid-operation discards the operation; the FSM leaves reset in IDLE.
- States: IDLE, RUN, FIX.
- IDLE, start=1, op=MTHI/MTLO: hi (or lo) <= src_a at that edge. Stay IDLE, no busy, no done.
- IDLE, start=1, op=MULT/MULTU/DIV/DIVU, src_b!=0 or multiply:
  - Latch operands at edge E0. Signed ops latch absolute values and record the result signs.
  - Go to RUN with counter=0.
- IDLE, start=1, op=DIV/DIVU, src_b==0:
  - At E0: lo<=32'hFFFFFFFF, hi<=src_a.
  - Stay IDLE. done=1 in the following cycle; busy never asserts.
- RUN: one iteration per edge E1..E32.
  - Multiply: 64-bit shift-add.
  - Divide: restoring, one quotient bit per step.
  - When counter==WIDTH-1 at an edge, go to FIX.
- FIX, edge E33:
  - Apply signs. Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; remainder takes the dividend sign.
  - Write hi/lo: product[63:32]/[31:0]; remainder/quotient.
  - Go to IDLE. done=1 for exactly the cycle after E33.
- busy/stall_req are high from after E0 through E33 (33 cycles).
- start while busy: ignored. The pipeline is stalled, so this only occurs through a design error, and the bench flags it as an error.
- flush=1, any state: next edge goes to IDLE. hi/lo unchanged, done=0.
- flush has priority over start in the same cycle; the request is dropped.
- Signed overflow, 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0. No trap.
- Arithmetic is modulo 2^WIDTH per field. The 64-bit product is never truncated before splitting.
- hi/lo change only on the edges listed above.

Test Plan:
- MULTU: src_a=src_b=32'hFFFFFFFF -> busy high 33 cycles, done pulse, hi=32'hFFFFFFFE, lo=32'h00000001.
- MULT: src_a=-3, src_b=5 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFF1. Then DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIVU: src_a=100, src_b=0 -> no busy, done next cycle, lo=32'hFFFFFFFF, hi=32'h00000064. Then DIV 0x80000000/-1 -> lo=32'h80000000, hi=0.
- MTHI 0x12345678, then MTLO 0x9ABCDEF0 on consecutive cycles -> hi/lo updated one edge after each; busy stays 0.
- Preload hi=0xA, lo=0xB. Start MULTU 7*9, assert flush on the 10th busy cycle -> IDLE next edge, hi=0xA, lo=0xB, no done.
- Start DIVU, drop rst_n asynchronously mid-RUN -> all outputs 0 immediately. After release, a fresh MULTU 6*7 gives lo=42, hi=0.
